// File: rtl/cu_multicycle_if.sv
// Control-unit bus: instruction fields and ALU flags in,
// datapath enables, muxes, counters and fault status out.
interface cu_multicycle_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             Zero;
    logic             Less;
    logic             LessU;
    logic             mem_ready;
    logic             mem_req;
    logic             MemWrite;
    logic             AdrSrc;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic [3:0]       ALUctrl;
    logic [2:0]       ImmSrc;
    logic [2:0]       funct3_o;
    logic [CNT_W-1:0] instret;
    logic             fault;
    logic [1:0]       fault_cause;

    modport master (
        input  op, funct3, funct7_5, Zero, Less, LessU, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        output ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, ImmSrc, funct3_o,
        output instret, fault, fault_cause
    );

    modport slave (
        output op, funct3, funct7_5, Zero, Less, LessU, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        input  ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, ImmSrc, funct3_o,
        input  instret, fault, fault_cause
    );
endinterface

// File: rtl/cu_multicycle.sv
// Multi-cycle RV32I control FSM with memory handshake timeout,
// illegal-instruction trap and retired-instruction counter.
module cu_multicycle #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    cu_multicycle_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W:0] LIMIT = (WAIT_W + 1)'(MEM_TIMEOUT);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b1011;
    localparam logic [3:0] ALU_IDLE = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_UTYPE, S_ALUWB,
        S_BRANCH, S_JAL, S_JALR, S_LINK, S_TRAP
    } state_t;

    state_t state, nxt;

    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instret;
    logic              fault;
    logic [1:0]        cause;
    logic [1:0]        trap_cause;
    logic              mem_state;
    logic              timeout;
    logic              retire;
    logic              illegal;
    logic              taken;

    logic       mem_req_c, mem_write_c, adr_c;
    logic       ir_c, pc_c, rw_c;
    logic [1:0] sa, sb, rs;
    logic [3:0] alu;
    logic [2:0] imm;

    function automatic logic [3:0] alu_dec(
        input logic [2:0] f3,
        input logic       f7,
        input logic       is_r
    );
        case (f3)
            3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = 4'b0101;
            3'b010:  alu_dec = 4'b1001;
            3'b011:  alu_dec = 4'b1010;
            3'b100:  alu_dec = 4'b0100;
            3'b101:  alu_dec = f7 ? 4'b0111 : 4'b0110;
            3'b110:  alu_dec = 4'b0011;
            default: alu_dec = 4'b0010;
        endcase
    endfunction

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                       (state == S_MEMWRITE);

    // limit counts elapsed wait cycles, including the current one
    assign timeout = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready &&
                     (({1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1}) == LIMIT);

    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = !bus.Zero;
            3'b100:  taken = bus.Less;
            3'b101:  taken = !bus.Less;
            3'b110:  taken = bus.LessU;
            3'b111:  taken = !bus.LessU;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_I:             imm = (bus.funct3[1:0] == 2'b01) ? 3'b001 : 3'b000;
            OP_STORE:         imm = 3'b010;
            OP_BR:            imm = 3'b011;
            OP_LUI, OP_AUIPC: imm = 3'b100;
            OP_JAL:           imm = 3'b101;
            default:          imm = 3'b000;
        endcase
    end

    always_comb begin
        nxt         = state;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        adr_c       = 1'b0;
        ir_c        = 1'b0;
        pc_c        = 1'b0;
        rw_c        = 1'b0;
        sa          = 2'b00;
        sb          = 2'b00;
        rs          = 2'b00;
        alu         = ALU_IDLE;
        illegal     = 1'b0;
        trap_cause  = 2'b00;
        unique case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                sb        = 2'b10;
                alu       = ALU_ADD;
                rs        = 2'b10;
                ir_c      = bus.mem_ready;
                pc_c      = bus.mem_ready;
                if (bus.mem_ready) nxt = S_DECODE;
                else if (timeout)  nxt = S_TRAP;
            end
            S_DECODE: begin
                sa  = 2'b01;
                sb  = 2'b01;
                alu = ALU_ADD;
                case (bus.op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R: begin
                        nxt     = S_EXECR;
                        illegal = bus.funct7_5 && (bus.funct3 != 3'b000) &&
                                  (bus.funct3 != 3'b101);
                    end
                    OP_I: begin
                        nxt     = S_EXECI;
                        illegal = bus.funct7_5 && (bus.funct3 == 3'b001);
                    end
                    OP_BR: begin
                        nxt     = S_BRANCH;
                        illegal = (bus.funct3[2:1] == 2'b01);
                    end
                    OP_JAL:           nxt = S_JAL;
                    OP_JALR:          nxt = S_JALR;
                    OP_LUI, OP_AUIPC: nxt = S_UTYPE;
                    default:          illegal = 1'b1;
                endcase
                if (illegal) nxt = S_TRAP;
            end
            S_MEMADR: begin
                sa  = 2'b10;
                sb  = 2'b01;
                alu = ALU_ADD;
                nxt = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_c     = 1'b1;
                if (bus.mem_ready) nxt = S_MEMWB;
                else if (timeout)  nxt = S_TRAP;
            end
            S_MEMWB: begin
                rs   = 2'b01;
                rw_c = 1'b1;
                nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_c       = 1'b1;
                if (bus.mem_ready) nxt = S_FETCH;
                else if (timeout)  nxt = S_TRAP;
            end
            S_EXECR: begin
                sa  = 2'b10;
                alu = alu_dec(bus.funct3, bus.funct7_5, 1'b1);
                nxt = S_ALUWB;
            end
            S_EXECI: begin
                sa  = 2'b10;
                sb  = 2'b01;
                alu = alu_dec(bus.funct3, bus.funct7_5, 1'b0);
                nxt = S_ALUWB;
            end
            S_UTYPE: begin
                sb = 2'b01;
                if (bus.op == OP_LUI) begin
                    alu = ALU_PASS;
                end else begin
                    sa  = 2'b01;
                    alu = ALU_ADD;
                end
                nxt = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c = 1'b1;
                nxt  = S_FETCH;
            end
            S_BRANCH: begin
                sa   = 2'b10;
                alu  = ALU_SUB;
                pc_c = taken;
                nxt  = S_FETCH;
            end
            S_JAL: begin
                pc_c = 1'b1;
                nxt  = S_LINK;
            end
            S_JALR: begin
                sa   = 2'b10;
                sb   = 2'b01;
                alu  = ALU_ADD;
                rs   = 2'b10;
                pc_c = 1'b1;
                nxt  = S_LINK;
            end
            S_LINK: begin
                sa   = 2'b01;
                sb   = 2'b10;
                alu  = ALU_ADD;
                rs   = 2'b10;
                rw_c = 1'b1;
                nxt  = S_FETCH;
            end
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_FETCH;
        endcase
        if (nxt == S_TRAP) trap_cause = illegal ? 2'b01 : 2'b10;
    end

    assign retire = (nxt == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                     (state == S_ALUWB) || (state == S_BRANCH) ||
                     (state == S_LINK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            instret  <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
            cause    <= 2'b00;
        end else begin
            state <= nxt;
            if (retire) instret <= instret + CNT_W'(1);
            if ((nxt != state) && ((nxt == S_FETCH) || (nxt == S_MEMREAD) ||
                                   (nxt == S_MEMWRITE)))
                wait_cnt <= '0;
            else if (mem_state && !bus.mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if ((nxt == S_TRAP) && (state != S_TRAP)) begin
                fault <= 1'b1;
                cause <= trap_cause;
            end
        end
    end

    // write strobes are suppressed for as long as reset is held
    assign bus.mem_req     = mem_req_c & ~rst;
    assign bus.MemWrite    = mem_write_c & ~rst;
    assign bus.IRWrite     = ir_c & ~rst;
    assign bus.PCWrite     = pc_c & ~rst;
    assign bus.RegWrite    = rw_c & ~rst;
    assign bus.AdrSrc      = adr_c;
    assign bus.ALUSrcA     = sa;
    assign bus.ALUSrcB     = sb;
    assign bus.ResultSrc   = rs;
    assign bus.ALUctrl     = alu;
    assign bus.ImmSrc      = imm;
    assign bus.funct3_o    = bus.funct3;
    assign bus.instret     = instret;
    assign bus.fault       = fault;
    assign bus.fault_cause = cause;
endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboard bench for cu_multicycle: per-cycle expected outputs are
// queued with their mem_ready stimulus and compared as cycles elapse.
module tb_cu_multicycle;
    localparam int CW = 32;

    typedef struct packed {
        logic        req;
        logic        mw;
        logic        adr;
        logic        irw;
        logic        pcw;
        logic        rw;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [2:0]  imm;
        logic [2:0]  f3;
        logic        flt;
        logic [1:0]  cause;
        logic [31:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ret = 0;

    exp_t  eq[$];
    bit    rq[$];
    string nq[$];

    cu_multicycle_if #(.CNT_W(CW)) bus ();

    cu_multicycle #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] imm_of(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0010011: imm_of = (f3 == 3'b001 || f3 == 3'b101) ? 3'd1 : 3'd0;
            7'b0100011: imm_of = 3'd2;
            7'b1100011: imm_of = 3'd3;
            7'b0110111: imm_of = 3'd4;
            7'b0010111: imm_of = 3'd4;
            7'b1101111: imm_of = 3'd5;
            default:    imm_of = 3'd0;
        endcase
    endfunction

    function automatic exp_t base();
        exp_t e = '0;
        e.alu = 4'hf;
        e.imm = imm_of(bus.op, bus.funct3);
        e.f3  = bus.funct3;
        e.ret = 32'(ret);
        return e;
    endfunction

    function automatic exp_t got();
        exp_t g;
        g.req   = bus.mem_req;
        g.mw    = bus.MemWrite;
        g.adr   = bus.AdrSrc;
        g.irw   = bus.IRWrite;
        g.pcw   = bus.PCWrite;
        g.rw    = bus.RegWrite;
        g.sa    = bus.ALUSrcA;
        g.sb    = bus.ALUSrcB;
        g.rs    = bus.ResultSrc;
        g.alu   = bus.ALUctrl;
        g.imm   = bus.ImmSrc;
        g.f3    = bus.funct3_o;
        g.flt   = bus.fault;
        g.cause = bus.fault_cause;
        g.ret   = bus.instret;
        return g;
    endfunction

    function automatic exp_t e_fetch(input bit rdy);
        exp_t e = base();
        e.req = 1'b1; e.irw = rdy; e.pcw = rdy;
        e.sb = 2'b10; e.rs = 2'b10; e.alu = 4'h0;
        return e;
    endfunction

    function automatic exp_t e_dec();
        exp_t e = base();
        e.sa = 2'b01; e.sb = 2'b01; e.alu = 4'h0;
        return e;
    endfunction

    function automatic exp_t e_memadr();
        exp_t e = base();
        e.sa = 2'b10; e.sb = 2'b01; e.alu = 4'h0;
        return e;
    endfunction

    function automatic exp_t e_memrd();
        exp_t e = base();
        e.req = 1'b1; e.adr = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memwb();
        exp_t e = base();
        e.rs = 2'b01; e.rw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memwr();
        exp_t e = base();
        e.req = 1'b1; e.mw = 1'b1; e.adr = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [1:0] sb, input logic [3:0] alu);
        exp_t e = base();
        e.sa = 2'b10; e.sb = sb; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t e_wb();
        exp_t e = base();
        e.rw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_branch(input bit tk);
        exp_t e = base();
        e.sa = 2'b10; e.alu = 4'h1; e.pcw = tk;
        return e;
    endfunction

    function automatic exp_t e_jal();
        exp_t e = base();
        e.pcw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_jalr();
        exp_t e = base();
        e.sa = 2'b10; e.sb = 2'b01; e.alu = 4'h0;
        e.rs = 2'b10; e.pcw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_link();
        exp_t e = base();
        e.sa = 2'b01; e.sb = 2'b10; e.alu = 4'h0;
        e.rs = 2'b10; e.rw = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_trap(input logic [1:0] c);
        exp_t e = base();
        e.flt = 1'b1; e.cause = c;
        return e;
    endfunction

    task automatic put(input string n, input bit rdy, input exp_t e);
        nq.push_back(n);
        rq.push_back(rdy);
        eq.push_back(e);
    endtask

    task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
    endtask

    task automatic run();
        exp_t  e;
        exp_t  g;
        string n;
        while (eq.size() > 0) begin
            bus.mem_ready = rq.pop_front();
            #1;
            g = got();
            e = eq.pop_front();
            n = nq.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, g, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string n);
        exp_t e;
        exp_t g;
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        ret = 0;
        #1;
        e = e_fetch(1'b0);
        e.req = 1'b0;
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, g, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_addi();
        set_ins(7'b0010011, 3'b000, 1'b0);
        put("addi_fetch", 1, e_fetch(1));
        put("addi_dec", 1, e_dec());
        put("addi_exec", 1, e_exec(2'b01, 4'h0));
        put("addi_wb", 1, e_wb());
        ret++;
        run();
    endtask

    task automatic test_load_wait();
        set_ins(7'b0000011, 3'b010, 1'b0);
        put("lw_fetch", 1, e_fetch(1));
        put("lw_dec", 1, e_dec());
        put("lw_adr", 1, e_memadr());
        for (int i = 0; i < 3; i++) put("lw_wait", 0, e_memrd());
        put("lw_rd", 1, e_memrd());
        put("lw_wb", 1, e_memwb());
        ret++;
        run();
    endtask

    task automatic test_branch();
        logic [2:0] f3s[6] = '{3'b000, 3'b000, 3'b110, 3'b110, 3'b101, 3'b101};
        bit         flg[6] = '{0, 1, 0, 1, 0, 1};
        bit         tk[6]  = '{0, 1, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            set_ins(7'b1100011, f3s[i], 1'b0);
            bus.Zero  = (i < 2) ? flg[i] : 1'b0;
            bus.LessU = (i == 2 || i == 3) ? flg[i] : 1'b1;
            bus.Less  = (i > 3) ? flg[i] : 1'b0;
            put("br_fetch", 1, e_fetch(1));
            put("br_dec", 1, e_dec());
            put("br_taken", 1, e_branch(tk[i]));
            ret++;
            run();
        end
    endtask

    task automatic test_rtype();
        logic [2:0] f3s[3] = '{3'b000, 3'b101, 3'b011};
        bit         f7s[3] = '{1, 1, 0};
        logic [3:0] al[3]  = '{4'h1, 4'h7, 4'ha};
        for (int i = 0; i < 3; i++) begin
            set_ins(7'b0110011, f3s[i], f7s[i]);
            put("r_fetch", 1, e_fetch(1));
            put("r_dec", 1, e_dec());
            put("r_exec", 1, e_exec(2'b00, al[i]));
            put("r_wb", 1, e_wb());
            ret++;
            run();
        end
    endtask

    task automatic test_store_wait();
        set_ins(7'b0100011, 3'b010, 1'b0);
        put("sw_fwait", 0, e_fetch(0));
        put("sw_fetch", 1, e_fetch(1));
        put("sw_dec", 1, e_dec());
        put("sw_adr", 1, e_memadr());
        put("sw_wait", 0, e_memwr());
        put("sw_wr", 1, e_memwr());
        ret++;
        run();
    endtask

    task automatic test_jump();
        set_ins(7'b1100111, 3'b000, 1'b0);
        put("jalr_fetch", 1, e_fetch(1));
        put("jalr_dec", 1, e_dec());
        put("jalr_exec", 1, e_jalr());
        put("jalr_link", 1, e_link());
        ret++;
        run();
        set_ins(7'b1101111, 3'b011, 1'b1);
        put("jal_fetch", 1, e_fetch(1));
        put("jal_dec", 1, e_dec());
        put("jal_exec", 1, e_jal());
        put("jal_link", 1, e_link());
        ret++;
        run();
    endtask

    task automatic test_utype();
        exp_t e;
        set_ins(7'b0110111, 3'b000, 1'b0);
        put("lui_fetch", 1, e_fetch(1));
        put("lui_dec", 1, e_dec());
        e = base(); e.sb = 2'b01; e.alu = 4'hb;
        put("lui_exec", 1, e);
        put("lui_wb", 1, e_wb());
        ret++;
        run();
        set_ins(7'b0010111, 3'b000, 1'b0);
        put("auipc_fetch", 1, e_fetch(1));
        put("auipc_dec", 1, e_dec());
        e = base(); e.sa = 2'b01; e.sb = 2'b01; e.alu = 4'h0;
        put("auipc_exec", 1, e);
        put("auipc_wb", 1, e_wb());
        ret++;
        run();
    endtask

    task automatic test_illegal();
        set_ins(7'b1111111, 3'b000, 1'b0);
        put("ill_fetch", 1, e_fetch(1));
        put("ill_dec", 1, e_dec());
        for (int i = 0; i < 3; i++) put("ill_trap", 1, e_trap(2'b01));
        run();
        do_reset("ill_reset");
        set_ins(7'b0110011, 3'b010, 1'b1);
        put("ill_r_fetch", 1, e_fetch(1));
        put("ill_r_dec", 1, e_dec());
        for (int i = 0; i < 2; i++) put("ill_r_trap", 1, e_trap(2'b01));
        run();
        do_reset("ill_r_reset");
    endtask

    task automatic test_timeout();
        set_ins(7'b0010011, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) put("to_wait", 0, e_fetch(0));
        for (int i = 0; i < 2; i++) put("to_trap", 1, e_trap(2'b10));
        run();
        do_reset("to_reset");
        for (int i = 0; i < 3; i++) put("lim_wait", 0, e_fetch(0));
        put("lim_ready", 1, e_fetch(1));
        put("lim_dec", 1, e_dec());
        put("lim_exec", 1, e_exec(2'b01, 4'h0));
        put("lim_wb", 1, e_wb());
        ret++;
        run();
        for (int i = 0; i < 2; i++) put("mid_wait", 0, e_fetch(0));
        run();
        do_reset("mid_reset");
        for (int i = 0; i < 3; i++) put("post_wait", 0, e_fetch(0));
        put("post_fetch", 1, e_fetch(1));
        put("post_dec", 1, e_dec());
        run();
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.Zero = 1'b0;
        bus.Less = 1'b0;
        bus.LessU = 1'b0;
        set_ins(7'b0010011, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_load_wait();
        test_branch();
        test_rtype();
        test_store_wait();
        test_jump();
        test_utype();
        test_illegal();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Multi-cycle RV32I control unit: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back over several cycles through a shared-memory datapath. It adds the following:
- a memory ready handshake with a parametrised timeout;
- illegal-instruction trapping with a sticky fault;
- a retired-instruction counter.

It sits between the instruction register / ALU flag outputs and the multi-cycle datapath's enables and muxes.

## Interface
- `CNT_W`, default 32: retired-instruction counter width.
- `MEM_TIMEOUT`, default 16: maximum cycles waiting for `mem_ready` in any memory state; 0 disables the timeout.

Clock and reset are fixed: one clock `clk`; reset `rst` is asynchronous and active-high.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `op`  in  7  opcode from the instruction register.
- `funct3`  in  3  from the instruction register.
- `funct7_5`  in  1  instruction bit 30.
- `Zero`, `Less`, `LessU`  in  1 each  ALU flags (combinational, current cycle).
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `MemWrite`  out  1  store strobe, valid while `mem_req`.
- `AdrSrc`  out  1  address mux: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  latch instruction and OldPC.
- `PCWrite`  out  1  PC register enable.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult.
- `ALUctrl`  out  4  ALU operation (encoding in Operation).
- `ImmSrc`  out  3  immediate format (encoding in Operation).
- `funct3_o`  out  3  `funct3` pass-through, used for load/store sizing.
- `instret`  out  `CNT_W`  retired-instruction count.
- `fault`  out  1  sticky trap flag.
- `fault_cause`  out  2  00 = none, 01 = illegal instruction, 10 = memory timeout.

## Operation

**ALUctrl encoding**
- 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll.
- 0110 srl, 0111 sra, 1001 slt, 1010 sltu, 1011 pass B.
- 1111 is the idle value.

**ImmSrc encoding**
- Combinational from `op` in every state.
- 000 I, 001 I-shamt (shift immediates), 010 S, 011 B, 100 U, 101 J.

**Defaults:** every enable is 0, muxes are 00, ALUctrl is 1111, unless the state below sets them.

**States**
- FETCH:
  - `mem_req`=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - `IRWrite`=`PCWrite`=`mem_ready`.
  - Go to DECODE on `mem_ready`.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add; ALUOut is loaded with OldPC+imm.
  - Route by opcode:
    - 0000011 and 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 and 0010111 → UTYPE
  - Go to TRAP (cause 01) on any of:
    - an unknown opcode;
    - R-type with `funct7_5`=1 and `funct3`∉{000,101};
    - SLLI with `funct7_5`=1;
    - branch `funct3`∈{010,011}.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD (load) or MEMWRITE (store).
- MEMREAD: `mem_req`=1, AdrSrc=1. Go to MEMWB on `mem_ready`.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: `mem_req`=1, `MemWrite`=1, AdrSrc=1. Go to FETCH on `mem_ready`.
- EXECR: ALUSrcA=10, ALUSrcB=00. Go to ALUWB.
  - `funct3` mapping: 000 gives add, or sub when `funct7_5`=1.
  - 100 xor, 110 or, 111 and, 001 sll, 101 srl or sra (by `funct7_5`), 010 slt, 011 sltu.
- EXECI: ALUSrcA=10, ALUSrcB=01. Same mapping as EXECR, except 000 is always add. Go to ALUWB.
- UTYPE: ALUSrcB=01; then go to ALUWB.
  - LUI: pass B.
  - AUIPC: ALUSrcA=01, add.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. `PCWrite` is set to taken. Go to FETCH.
  - Taken per `funct3`: 000 `Zero`, 001 ~`Zero`, 100 `Less`, 101 ~`Less`, 110 `LessU`, 111 ~`LessU`.
- JAL: ResultSrc=00, `PCWrite`=1. Go to LINK.
- JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, `PCWrite`=1. Go to LINK. The datapath clears bit 0 of the target.
- LINK: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1. Go to FETCH.
- TRAP:
  - All enables 0, `fault`=1, `fault_cause` held.
  - Exits only on reset.

**Counters**
- `instret` increments on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or LINK.
- It wraps modulo 2^`CNT_W`.
- `wait_cnt` clears on entry to FETCH, MEMREAD and MEMWRITE, and increments each cycle `mem_ready`=0 in those states.
- When `MEM_TIMEOUT`≠0 and `wait_cnt` reaches `MEM_TIMEOUT` with `mem_ready`=0: go to TRAP, cause 10.
- `mem_ready` in the same cycle as the limit wins: the access completes normally.

## Timing
- Reset (asynchronous):
  - State = FETCH; `instret`=0, `wait_cnt`=0, `fault`=0, `fault_cause`=00.
  - While `rst`=1: `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `mem_req` are forced 0.
- Reset asserted mid-instruction aborts it immediately; no write strobe is issued after `rst` rises.
- Cycles per instruction with zero memory wait:
  - branch 3;
  - R, I, U-type, store, JAL, JALR 4;
  - load 5.
  - Each `mem_ready`=0 cycle adds one.
- `PCWrite`, `IRWrite` and `MemWrite` are combinational from state plus inputs and take effect at the next rising edge. `mem_ready` must be valid before that edge.
- `mem_req` stays high continuously until `mem_ready` is seen. Request attributes (AdrSrc, `MemWrite`) stay stable while waiting.

## Test plan
- Reset, then `addi` (op 0010011, `funct3` 000) with `mem_ready`=1 → states FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in cycle 4 only; `instret`=1 after cycle 4.
- `lw` with `mem_ready` held low 3 cycles in MEMREAD → `mem_req` high 4 cycles at AdrSrc=1; RegWrite with ResultSrc=01 in MEMWB; 8 cycles total.
- `beq`, `bltu`, `bge` with `Zero`/`LessU`/`Less` each both 0 and 1 → `PCWrite` in BRANCH equals the taken rule; `instret` +1 each.
- `jalr` → `PCWrite`=1 with ResultSrc=10 in JALR, then RegWrite=1 with ALUSrcA=01, ALUSrcB=10 in LINK.
- Illegal instructions:
  - op 1111111 → TRAP after DECODE, `fault`=1, `fault_cause`=01, `mem_req` stays 0 thereafter.
  - R-type `funct3`=010 with `funct7_5`=1 → same trap.
- Timeouts:
  - `MEM_TIMEOUT`=4, `mem_ready` never asserted in FETCH → TRAP after 4 wait cycles, cause 10.
  - `rst` pulse mid-wait → FETCH, `fault`=0.
